retire_trace_buffer: RTL

Sink for the core's retirement port (update/pc/instr/rd/wb-data). Captures every retirement into a small FIFO and tags each entry with a sequence number. Drains entries to a trace consumer (host logger, UART bridge, or testbench scoreboard) over a valid/ready handshake. Counts retirements lost to back-pressure so that gaps are detectable downstream.

---
 rtl/retire_trace_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/retire_trace_buffer.sv
// -----------------------------------------------------------------------------
// retire_trace_buffer
// Captures every core retirement into a small FIFO. Each entry carries a
// wrapping sequence tag. Entries drain to a trace consumer over a valid/ready
// handshake. Retirements lost to back-pressure are counted, so gaps in the
// trace can be detected downstream.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   update_i                retirement strobe, one retirement per high cycle
//   pc_i/instr_i/reg_*_i    retired PC, instruction, rd, write-back value
//   trace_valid_o/ready_i   head-entry handshake toward the consumer
//   trace_*_o               head entry fields; read 0 while trace_valid_o=0
//   count_o                 current occupancy, 0..DEPTH
//   drop_cnt_o              saturating count of retirements dropped while full
//   overflow_o              sticky, set on the first drop
// -----------------------------------------------------------------------------
module retire_trace_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SEQW  = 16,
    parameter int unsigned DROPW = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     update_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [4:0]               reg_addr_i,
    input  logic [XLEN-1:0]          reg_data_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output logic [XLEN-1:0]          trace_pc_o,
    output logic [XLEN-1:0]          trace_instr_o,
    output logic [4:0]               trace_rd_o,
    output logic [XLEN-1:0]          trace_data_o,
    output logic [SEQW-1:0]          trace_seq_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DROPW-1:0]         drop_cnt_o,
    output logic                     overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Entry storage; deliberately not reset.
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic [4:0]      r_rd_mem    [DEPTH];
    logic [XLEN-1:0] r_data_mem  [DEPTH];
    logic [SEQW-1:0] r_seq_mem   [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [SEQW-1:0]  r_seq;
    logic [DROPW-1:0] r_drop_cnt;
    logic             r_overflow;

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Handshake decode. A pop frees a slot in the same cycle, so a full FIFO
    // still accepts a retirement when the head is consumed.
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = w_valid && trace_ready_i;
    assign w_push  = update_i && (!w_full || w_pop);
    assign w_drop  = update_i && w_full && !w_pop;

    // Pointers, occupancy, sequence tag and drop bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Tag advances on every retirement, dropped or not, exposing gaps.
            if (update_i) begin
                r_seq <= r_seq + SEQW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + DROPW'(1);
                end
            end
        end
    end

    // Entry write at the tail.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= pc_i;
            r_instr_mem[r_wr_ptr] <= instr_i;
            r_rd_mem[r_wr_ptr]    <= reg_addr_i;
            r_data_mem[r_wr_ptr]  <= reg_data_i;
            r_seq_mem[r_wr_ptr]   <= r_seq;
        end
    end

    // Head entry, forced to zero while empty.
    always_comb begin
        trace_pc_o    = '0;
        trace_instr_o = '0;
        trace_rd_o    = '0;
        trace_data_o  = '0;
        trace_seq_o   = '0;
        if (w_valid) begin
            trace_pc_o    = r_pc_mem[r_rd_ptr];
            trace_instr_o = r_instr_mem[r_rd_ptr];
            trace_rd_o    = r_rd_mem[r_rd_ptr];
            trace_data_o  = r_data_mem[r_rd_ptr];
            trace_seq_o   = r_seq_mem[r_rd_ptr];
        end
    end

    assign trace_valid_o = w_valid;
    assign count_o       = r_count;
    assign drop_cnt_o    = r_drop_cnt;
    assign overflow_o    = r_overflow;

endmodule
